// File: rtl/lpm_inv_pipe_if.sv
// Handshake bundle for lpm_inv_pipe: producer side, consumer side and status.
// The result_par signal exists only when LPM_INV_PIPE_PARITY_EN is defined.
interface lpm_inv_pipe_if #(
    parameter int lpm_width = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           mode;
    logic [lpm_width-1:0] mask;
    logic [lpm_width-1:0] data;
    logic                 out_valid;
    logic                 out_ready;
    logic [lpm_width-1:0] result;
    logic                 busy;
`ifdef LPM_INV_PIPE_PARITY_EN
    logic                 result_par;
`endif

    modport slave (
        input  in_valid, mode, mask, data, out_ready,
`ifdef LPM_INV_PIPE_PARITY_EN
        output result_par,
`endif
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, mode, mask, data, out_ready,
`ifdef LPM_INV_PIPE_PARITY_EN
        input  result_par,
`endif
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/lpm_inv_pipe.sv
// Pipelined inverter/logic unit with valid/ready backpressure, clken and sclr.
// Optional result parity output enabled by defining LPM_INV_PIPE_PARITY_EN.
module lpm_inv_pipe #(
    parameter int    lpm_width    = 8,
    parameter int    lpm_pipeline = 2,
    parameter string lpm_type     = "lpm_inv_pipe",
    parameter string lpm_hint     = "UNUSED"
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clken,
    input  logic          sclr,
    lpm_inv_pipe_if.slave bus
);

    if (lpm_width < 1 || lpm_pipeline < 0 || lpm_pipeline > 8) begin : g_bad_param
        $fatal(1, "%m: illegal parameters lpm_width=%0d lpm_pipeline=%0d (%s/%s)",
               lpm_width, lpm_pipeline, lpm_type, lpm_hint);
    end

    function automatic logic [lpm_width-1:0] op_f(
        input logic [1:0]           m,
        input logic [lpm_width-1:0] d,
        input logic [lpm_width-1:0] k
    );
        case (m)
            2'd0:    op_f = ~d;
            2'd1:    op_f = d;
            2'd2:    op_f = d ^ k;
            default: op_f = d & ~k;
        endcase
    endfunction

    logic [lpm_width-1:0] op_w;
    assign op_w = op_f(bus.mode, bus.data, bus.mask);
`ifdef LPM_INV_PIPE_PARITY_EN
    logic par_w;
    assign par_w = ^op_w;
`endif

    if (lpm_pipeline == 0) begin : g_comb
        // No registers: the operation result feeds the consumer directly.
        assign bus.in_ready  = reset_n & clken & ~sclr & bus.out_ready;
        assign bus.out_valid = reset_n & clken & ~sclr & bus.in_valid;
        assign bus.result    = reset_n ? op_w : '0;
        assign bus.busy      = 1'b0;
`ifdef LPM_INV_PIPE_PARITY_EN
        assign bus.result_par = reset_n & par_w;
`endif
    end else begin : g_pipe
        localparam int P = lpm_pipeline;

        logic [P-1:0]         vld_p;
        logic [lpm_width-1:0] data_p [P];
        logic [P-1:0]         rdy;
        logic [P-1:0]         up_vld;
        logic [lpm_width-1:0] up_data [P];
        logic                 rdy_acc;
`ifdef LPM_INV_PIPE_PARITY_EN
        logic [P-1:0]         par_p;
        logic [P-1:0]         up_par;
`endif

        // A stage may advance when any stage downstream of it has a hole,
        // or the consumer takes the last one; this lets bubbles collapse.
        always_comb begin
            rdy     = '0;
            rdy_acc = bus.out_ready;
            for (int i = P - 1; i >= 0; i--) begin
                rdy[i]  = rdy_acc;
                rdy_acc = rdy_acc | ~vld_p[i];
            end
        end

        always_comb begin
            up_vld     = '0;
            up_vld[0]  = bus.in_valid;
            up_data[0] = op_w;
            for (int i = 1; i < P; i++) begin
                up_vld[i]  = vld_p[i-1];
                up_data[i] = data_p[i-1];
            end
        end

`ifdef LPM_INV_PIPE_PARITY_EN
        always_comb begin
            up_par    = '0;
            up_par[0] = par_w;
            for (int i = 1; i < P; i++) up_par[i] = par_p[i-1];
        end
`endif

        // Stage registers: reset clears everything, sclr clears valids only.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_p <= '0;
                for (int i = 0; i < P; i++) data_p[i] <= '0;
`ifdef LPM_INV_PIPE_PARITY_EN
                par_p <= '0;
`endif
            end else if (sclr) begin
                vld_p <= '0;
            end else if (clken) begin
                for (int i = 0; i < P; i++) begin
                    if (!vld_p[i] || rdy[i]) begin
                        vld_p[i]  <= up_vld[i];
                        data_p[i] <= up_data[i];
`ifdef LPM_INV_PIPE_PARITY_EN
                        par_p[i]  <= up_par[i];
`endif
                    end
                end
            end
        end

        // Output boundary.
        assign bus.in_ready  = reset_n & clken & ~sclr & (~vld_p[0] | rdy[0]);
        assign bus.out_valid = vld_p[P-1];
        assign bus.result    = data_p[P-1];
        assign bus.busy      = |vld_p;
`ifdef LPM_INV_PIPE_PARITY_EN
        assign bus.result_par = par_p[P-1];
`endif
    end

endmodule

// File: tb/tb_lpm_inv_pipe.sv
// Directed bench for lpm_inv_pipe: a 2-stage unit and a 0-stage unit side by side.
// Covers streaming, all modes, backpressure, clken/sclr, async reset and parity.
module tb_lpm_inv_pipe;

    logic clock = 1'b0;
    logic reset_n;
    logic clken;
    logic sclr;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    lpm_inv_pipe_if #(.lpm_width(8)) b  ();
    lpm_inv_pipe_if #(.lpm_width(8)) b0 ();

    lpm_inv_pipe #(.lpm_width(8), .lpm_pipeline(2)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clken   (clken),
        .sclr    (sclr),
        .bus     (b)
    );

    lpm_inv_pipe #(.lpm_width(8), .lpm_pipeline(0)) u_dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .clken   (clken),
        .sclr    (sclr),
        .bus     (b0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
        b.in_valid = v;
        b.data     = d;
        b.mode     = m;
        b.mask     = k;
    endtask

    initial begin
        reset_n      = 1'b0;
        clken        = 1'b1;
        sclr         = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        b.out_ready  = 1'b1;
        b0.in_valid  = 1'b0;
        b0.data      = 8'h00;
        b0.mode      = 2'd0;
        b0.mask      = 8'h00;
        b0.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(b.out_valid), 32'd0);
        chk("rst_result",    32'(b.result),    32'h00);
        chk("rst_busy",      32'(b.busy),      32'd0);
        chk("rst_in_ready",  32'(b.in_ready),  32'd0);
        reset_n = 1'b1;

        // Stream two items, latency 2
        drive(1'b1, 8'h0F, 2'd0, 8'h00);
        #1;
        chk("s_in_ready", 32'(b.in_ready), 32'd1);
        step();
        chk("s_busy1",  32'(b.busy),      32'd1);
        chk("s_early",  32'(b.out_valid), 32'd0);
        drive(1'b1, 8'hA5, 2'd1, 8'h00);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        chk("s_vld1",   32'(b.out_valid), 32'd1);
        chk("s_res1",   32'(b.result),    32'hF0);
        chk("s_busy2",  32'(b.busy),      32'd1);
        step();
        chk("s_vld2",   32'(b.out_valid), 32'd1);
        chk("s_res2",   32'(b.result),    32'hA5);
        chk("s_busy3",  32'(b.busy),      32'd1);
        step();
        chk("s_drain",  32'(b.out_valid), 32'd0);
        chk("s_idle",   32'(b.busy),      32'd0);

        // Modes 2 and 3
        drive(1'b1, 8'hCC, 2'd2, 8'hF0);
        step();
        drive(1'b1, 8'hCC, 2'd3, 8'hF0);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        chk("m2_res", 32'(b.result), 32'h3C);
        step();
        chk("m3_res", 32'(b.result), 32'h0C);
        step();
        chk("m_drain", 32'(b.out_valid), 32'd0);

        // Backpressure
        b.out_ready = 1'b0;
        drive(1'b1, 8'h01, 2'd0, 8'h00);
        #1;
        chk("bp_rdy1", 32'(b.in_ready), 32'd1);
        step();
        drive(1'b1, 8'h02, 2'd0, 8'h00);
        chk("bp_rdy2", 32'(b.in_ready), 32'd1);
        step();
        drive(1'b1, 8'h03, 2'd0, 8'h00);
        chk("bp_full",    32'(b.in_ready),  32'd0);
        chk("bp_vld",     32'(b.out_valid), 32'd1);
        chk("bp_hold1",   32'(b.result),    32'hFE);
        step();
        chk("bp_hold2",   32'(b.result),    32'hFE);
        chk("bp_full2",   32'(b.in_ready),  32'd0);
        b.out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(b.in_ready),  32'd1);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        chk("bp_out2", 32'(b.result),    32'hFD);
        chk("bp_v2",   32'(b.out_valid), 32'd1);
        step();
        chk("bp_out3", 32'(b.result),    32'hFC);
        chk("bp_v3",   32'(b.out_valid), 32'd1);
        step();
        chk("bp_nodup", 32'(b.out_valid), 32'd0);

        // clken freeze then sclr
        drive(1'b1, 8'h10, 2'd1, 8'h00);
        step();
        drive(1'b1, 8'h20, 2'd1, 8'h00);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        clken = 1'b0;
        #1;
        chk("ce_in_ready", 32'(b.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ce_vld", 32'(b.out_valid), 32'd1);
            chk("ce_res", 32'(b.result),    32'h10);
        end
        sclr = 1'b1;
        #1;
        chk("sclr_in_ready", 32'(b.in_ready), 32'd0);
        step();
        sclr  = 1'b0;
        clken = 1'b1;
        chk("sclr_vld",  32'(b.out_valid), 32'd0);
        chk("sclr_busy", 32'(b.busy),      32'd0);
        step();
        chk("sclr_stale1", 32'(b.out_valid), 32'd0);
        step();
        chk("sclr_stale2", 32'(b.out_valid), 32'd0);

        // Async reset with a full, stalled pipeline
        b.out_ready = 1'b0;
        drive(1'b1, 8'h55, 2'd1, 8'h00);
        step();
        drive(1'b1, 8'h66, 2'd1, 8'h00);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        chk("ar_full_vld", 32'(b.out_valid), 32'd1);
        chk("ar_full_res", 32'(b.result),    32'h55);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_vld",  32'(b.out_valid), 32'd0);
        chk("ar_res",  32'(b.result),    32'h00);
        chk("ar_busy", 32'(b.busy),      32'd0);
        chk("ar_rdy",  32'(b.in_ready),  32'd0);
        @(negedge clock);
        reset_n     = 1'b1;
        b.out_ready = 1'b1;
        drive(1'b1, 8'h00, 2'd0, 8'h00);
        step();
        drive(1'b0, 8'h00, 2'd0, 8'h00);
        chk("ar_lat1", 32'(b.out_valid), 32'd0);
        step();
        chk("ar_new_vld", 32'(b.out_valid), 32'd1);
        chk("ar_new_res", 32'(b.result),    32'hFF);

        // Zero-depth unit
        b0.in_valid  = 1'b1;
        b0.data      = 8'h07;
        b0.mode      = 2'd0;
        b0.out_ready = 1'b1;
        #1;
        chk("p0_res",  32'(b0.result),    32'hF8);
        chk("p0_vld",  32'(b0.out_valid), 32'd1);
        chk("p0_rdy1", 32'(b0.in_ready),  32'd1);
        chk("p0_busy", 32'(b0.busy),      32'd0);
`ifdef LPM_INV_PIPE_PARITY_EN
        chk("p0_par",  32'(b0.result_par), 32'd1);
`endif
        b0.out_ready = 1'b0;
        #1;
        chk("p0_rdy0", 32'(b0.in_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
